// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Packs incoming bytes big-endian into 32-bit words, writes them to
// consecutive word addresses from 0, then checks a trailing XOR checksum.
// The processor is held in reset (cpu_hold) until a load verifies.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    // Word counter is one bit wider than the address so a full-capacity
    // load can count to 2^ADDR_WIDTH without wrapping back to zero.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAX_WORDS = CW'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]         word_cnt;
    logic [CW-1:0]         word_cnt_inc;
    logic [CW-1:0]         num_q;
    logic [1:0]            byte_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] word_full;
    logic                  accept;
    logic                  last_byte;
    logic                  idle_like;
    logic                  count_ok;

    // The word as it stands once the byte on the bus is shifted in.
    assign word_full    = {shift_q[DATA_WIDTH-9:0], byte_in};
    assign word_cnt_inc = word_cnt + CW'(1);
    assign accept       = byte_valid && byte_ready;
    assign last_byte    = accept && (byte_cnt == 2'd3);
    assign idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign count_ok     = (num_words != '0) && (num_words <= MAX_WORDS);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the handshake/status outputs that follow state.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a
        // variable unassigned and a latch cannot be inferred.
        state_next = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) state_next = count_ok ? S_RECV : S_ERROR;
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (last_byte) state_next = S_WRITE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                state_next = (word_cnt_inc == num_q) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (last_byte) state_next = (word_full == acc) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: byte packing, write strobe, checksum and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            num_q    <= '0;
            byte_cnt <= '0;
            shift_q  <= '0;
            acc      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            if (idle_like && load_start) begin
                cpu_hold <= 1'b1;
                if (count_ok) begin
                    error    <= 1'b0;
                    acc      <= '0;
                    word_cnt <= '0;
                    byte_cnt <= '0;
                    num_q    <= num_words;
                end else begin
                    error <= 1'b1;
                end
            end

            if (accept) begin
                shift_q  <= word_full;
                byte_cnt <= byte_cnt + 2'd1;
            end

            // Write is registered so it lands in the cycle after the 4th byte
            // and address/data hold their values between strobes.
            if ((state == S_RECV) && last_byte) begin
                wr_en   <= 1'b1;
                wr_addr <= word_cnt[ADDR_WIDTH-1:0];
                wr_data <= word_full;
            end

            if (state == S_WRITE) begin
                acc      <= acc ^ wr_data;
                word_cnt <= word_cnt_inc;
            end

            if ((state == S_CHECK) && last_byte) begin
                if (word_full == acc) begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Expected writes and checksum outcome
// come from a word-level model: word i goes to address i, the checksum is the
// XOR of all words, and success means the sent checksum equals that XOR.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] stim_words[$];
    logic [39:0] act_q[$];
    int          done_cnt = 0;

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .num_words  (num_words),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    // Record memory writes and done pulses, sampled away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && wr_en) act_q.push_back({wr_addr, wr_data});
        if (rst_n && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input int n);
        byte_valid = 1'b0;
        load_start = 1'b1;
        num_words  = (AW+1)'(n);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offer one byte (optionally after random idle gaps) until it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_in    = b;
        guard      = 0;
        while (!byte_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                check("byte_timeout", 64'd1, 64'd0);
                return;
            end
        end
        @(negedge clk);
    endtask

    // Drive a full load from stim_words; inj >= 0 pulses a stray load_start
    // before that byte index; returns true when the checksum was intact.
    task automatic run_load(input int n, input bit corrupt, input bit gaps, input int inj);
        logic [31:0] cs;
        logic [31:0] w;
        act_q.delete();
        done_cnt = 0;
        cs = '0;
        for (int i = 0; i < n; i++) cs ^= stim_words[i];
        if (corrupt) cs ^= 32'h1;
        start(n);
        for (int i = 0; i < n * 4; i++) begin
            if (i == inj) begin
                byte_valid = 1'b0;
                load_start = 1'b1;
                num_words  = (AW+1)'(n + 3);
                @(negedge clk);
                load_start = 1'b0;
                num_words  = (AW+1)'(n);
            end
            w = stim_words[i / 4];
            send_byte(8'(w >> (24 - 8 * (i % 4))), gaps);
        end
        for (int i = 0; i < 4; i++) send_byte(8'(cs >> (24 - 8 * i)), gaps);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_load(input string tag, input int n, input bit corrupt);
        check({tag, "_nwrites"}, 64'(act_q.size()), 64'(n));
        for (int i = 0; i < n && i < act_q.size(); i++) begin
            check({tag, "_addr"}, 64'(act_q[i][39:32]), 64'(i % 256));
            check({tag, "_data"}, 64'(act_q[i][31:0]), 64'(stim_words[i]));
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), corrupt ? 64'd0 : 64'd1);
        check({tag, "_error"}, 64'(error), 64'(corrupt));
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(corrupt));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic set_happy();
        stim_words.delete();
        stim_words.push_back(32'h0000_8020);
        stim_words.push_back(32'h2010_0078);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, with a byte offered in IDLE that must not be taken.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        @(negedge clk);
        check("idle_no_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;

        // Happy path.
        set_happy();
        run_load(2, 1'b0, 1'b0, -1);
        check_load("happy", 2, 1'b0);

        // Bad checksum, then a good load clears error.
        run_load(2, 1'b1, 1'b0, -1);
        check_load("badcs", 2, 1'b1);
        run_load(2, 1'b0, 1'b0, -1);
        check_load("recover", 2, 1'b0);

        // Stalls with random gaps.
        run_load(2, 1'b0, 1'b1, -1);
        check_load("stall", 2, 1'b0);

        // Illegal counts.
        act_q.delete();
        start(0);
        @(negedge clk);
        check("zero_error", 64'(error), 64'd1);
        check("zero_cpu_hold", 64'(cpu_hold), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        start(300);
        repeat (2) @(negedge clk);
        check("over_error", 64'(error), 64'd1);
        check("illegal_nwrites", 64'(act_q.size()), 64'd0);

        // Full-capacity load, data = address.
        stim_words.delete();
        for (int i = 0; i < 256; i++) stim_words.push_back(32'(i));
        run_load(256, 1'b0, 1'b1, -1);
        check_load("full", 256, 1'b0);
        if (act_q.size() == 256) check("full_last_addr", 64'(act_q[255][39:32]), 64'd255);

        // Reset after the 6th byte of the happy-path load.
        set_happy();
        act_q.delete();
        start(2);
        for (int i = 0; i < 6; i++) send_byte(8'(stim_words[i / 4] >> (24 - 8 * (i % 4))), 1'b0);
        byte_valid = 1'b0;
        check("midload_one_write", 64'(act_q.size()), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(2, 1'b0, 1'b0, -1);
        check_load("after_reset", 2, 1'b0);

        // Stray load_start during RECV is ignored.
        run_load(2, 1'b0, 1'b0, 2);
        check_load("ignored_start", 2, 1'b0);

        // Random loads against the word-level model.
        for (int t = 0; t < 6; t++) begin
            int n;
            bit bad;
            n   = $urandom_range(1, 8);
            bad = 1'($urandom_range(0, 1));
            stim_words.delete();
            for (int i = 0; i < n; i++) stim_words.push_back($urandom);
            run_load(n, bad, 1'b1, -1);
            check_load("random", n, bad);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write-side counterpart of the processor's read-only instruction memory.
- Receives a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0, then verifies a trailing XOR checksum.
- Holds the processor in reset (cpu_hold) until a load completes with a matching checksum.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; fixed at 4 bytes, and other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  single-cycle pulse that begins a load; sampled only in IDLE, DONE or ERROR.
- num_words  input  ADDR_WIDTH+1  number of words to load (1..256); sampled with load_start.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte this cycle; transfer when byte_valid && byte_ready.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_WIDTH  word address for wr_en.
- wr_data  output  DATA_WIDTH  word for wr_en.
- busy  output  1  high in RECV, WRITE and CHECK.
- done  output  1  one-cycle pulse on checksum match.
- error  output  1  sticky; set on checksum mismatch or illegal num_words.
- cpu_hold  output  1  high keeps the processor in reset.

Behaviour:
- Reset values:
  - byte_ready, wr_en, busy, done and error are 0.
  - wr_addr and wr_data are 0.
  - cpu_hold is 1; the processor never runs before a successful load.
  - Internal word counter, byte counter and checksum accumulator are 0; state is IDLE.
- Reset mid-operation: returns to the reset state immediately.
  - Words already written stay in memory.
  - No wr_en glitch is allowed during or after reset assertion.
- IDLE/DONE/ERROR, on load_start:
  - num_words of 0 or greater than 256: go to ERROR, set error=1, keep cpu_hold=1.
  - Otherwise: clear error and the accumulator, set the word counter to 0 and cpu_hold to 1, and go to RECV.
- RECV: byte_ready=1.
  - Each accepted byte shifts into the word register; the first byte becomes bits [31:24] and the fourth byte bits [7:0].
  - Cycles with byte_valid low do not advance the byte count, so gaps are allowed.
  - On the 4th accepted byte: go to WRITE.
- WRITE: exactly one cycle, byte_ready=0.
  - wr_en=1, wr_addr = word counter, wr_data = assembled word.
  - The accumulator is XORed with the word; the word counter increments.
  - If the counter now equals num_words: go to CHECK. Otherwise return to RECV.
  - Latency: wr_en is asserted the cycle after the 4th byte handshake.
- Address wrap: a 256-word load ends with wr_addr=255; the counter is ADDR_WIDTH+1 bits so it reaches 256 without aliasing.
- CHECK: byte_ready=1; collect 4 bytes big-endian with no memory write.
  - The cycle after the 4th byte, compare against the accumulator.
  - Equal: done=1 for one cycle, cpu_hold=0, go to DONE.
  - Unequal: error=1, cpu_hold=1, go to ERROR.
- Outside RECV and CHECK, byte_ready=0 and offered bytes are not consumed.
- load_start while busy is ignored.
- load_start in the same cycle as a byte handshake in IDLE: load_start wins, and that byte is not consumed because byte_ready=0.
- wr_addr and wr_data hold their last written values when wr_en=0.

Test Plan:
- Happy path:
  - Stimulus: reset; load_start with num_words=2; bytes 00 00 80 20 20 10 00 78, then checksum 20 10 80 58.
  - Required: wr_en pulses at addr 0 with data 0x00008020 and at addr 1 with data 0x20100078; done pulses once; cpu_hold falls to 0; error stays 0.
- Bad checksum:
  - Stimulus: same load as the happy path, but checksum 20 10 80 59.
  - Required: both writes occur; error=1; cpu_hold stays 1; no done pulse.
  - Follow-up: a subsequent valid load clears error.
- Stalls:
  - Stimulus: insert random byte_valid=0 gaps, and hold byte_valid=1 through the WRITE cycle.
  - Required: identical writes to the happy path; the byte offered during WRITE is taken only after return to RECV, with no byte lost or duplicated.
- Boundary counts:
  - num_words=0: error=1 immediately and no writes.
  - num_words=256 with data = address: 256 writes ending with wr_addr=255, correct checksum, done asserted.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after the 6th byte of the happy-path load.
  - Required: outputs return to reset values at once with cpu_hold=1; a fresh load afterward writes again from addr 0.
- Ignored start:
  - Stimulus: load_start pulses during RECV with a different num_words.
  - Required: no effect; the original count completes.
